fp_norm_round_seq: RTL and testbench
====================================

Name: fp_norm_round_seq

Overview:
- Post-add normalisation and rounding stage of the IEEE-754 single-precision adder.
- Sits directly downstream of the mantissa add/subtract stage. Takes the raw signed-magnitude sum (carry, hidden, fraction, guard, sticky) and returns a packed 32-bit result.
- Leading-one search runs on an 8-bit window per cycle through the team's 8-bit priority circuit. Normalisation is byte-coarse, then bit-fine.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, stored fraction width (in_mant width = FRAC_W+4)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_sign  input  1  result sign from upstream
- in_exp  input  8  biased exponent referenced to in_mant[25]; range 1..254 (upstream maps subnormal operands to 1)
- in_mant  input  27  {carry[26], hidden[25], frac[24:2], guard[1], sticky[0]}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_overflow  output  1  result rounded/normalised to infinity
- out_inexact  output  1  guard|sticky nonzero at rounding

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_inexact=0. An in-flight operation is discarded.
- IDLE: on in_valid&in_ready, register sign/exp/mant → NORM_BYTE.
- NORM_BYTE, first matching rule wins:
  - (a) mant[26]=1: mant>>=1 with mant[0]=old[1]|old[0]; exp+=1 → ROUND.
  - (b) mant==0: result={sign,31'b0}, inexact=0 → OUT.
  - (c) mant[25:18]==0 and exp>8: mant<<=8 (zeros in), exp-=8, stay.
  - (d) else → NORM_BIT.
- NORM_BIT:
  - k = leading-zero count of mant[25:18], taken from the priority circuit's one-hot (k=8 if window zero).
  - s=min(k, exp-1); mant<<=s; exp-=s.
  - If mant[25]=0 afterwards, set subnormal flag (exp field 0).
  - → ROUND.
- ROUND (round-to-nearest-even):
  - lsb=mant[2], g=mant[1], st=mant[0]. Round up iff g&(st|lsb). inexact=g|st.
  - Increment adds 1 at bit 2. If the carry reaches bit 26: >>1, exp+=1.
  - Subnormal that rounds up into bit 25 → exp field=1.
  - If exp≥255 after any step: result={sign,8'hFF,23'b0}, overflow=1.
  - → OUT.
- OUT: out_valid=1; result and flags held stable while out_ready=0. On out_valid&out_ready → IDLE, out_valid=0 next cycle.
- in_ready=0 in every state except IDLE; a new input is not accepted in the same cycle as an output handshake.
- Latency, counted from the accepting edge to out_valid high:
  - zero: 1 cycle
  - carry: 2 cycles
  - already normalised: 3 cycles
  - +1 cycle per byte shift
- Exponent arithmetic is 10-bit internally; no wrap-around into the field.
- NORM_BIT never shifts exp below 1.

Test Plan:
- exp=127, mant=27'h2000000, sign=0 → out_result=32'h3F800000, inexact=0, out_valid 3 cycles after accept.
- exp=127, mant=27'h4000000 (1.0+1.0 carry) → 32'h40000000, latency 2.
- exp=127, mant=27'h0000004 (massive cancellation) → 2 byte shifts + bit shift 7, exp 104 → 32'h34000000, latency 5.
- exp=127, mant=27'h3FFFFFE (all-ones frac, g=1, st=0, lsb=1) → round-up carry → 32'h40000000, inexact=1.
- exp=254, mant=27'h4000000 → 32'h7F800000, overflow=1. Also mant=0, sign=1 → 32'h80000000, latency 1.
- exp=1, mant=27'h1000000 → subnormal 32'h00400000.
- Backpressure: out_ready low 4 cycles → result stable, in_ready=0.
- reset pulsed in NORM_BYTE → next cycle IDLE, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/fp_norm_round_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round_seq_if
// Description : Upstream/downstream handshake bundle for the single-precision
//               post-add normalise/round stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_norm_round_seq_if #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
);
   // Upstream side: raw signed-magnitude sum from the mantissa adder
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic [EXP_W-1:0]        in_exp;
   logic [FRAC_W+3:0]       in_mant;

   // Downstream side: packed IEEE-754 result and flags
   logic                    out_valid;
   logic                    out_ready;
   logic [EXP_W+FRAC_W:0]   out_result;
   logic                    out_overflow;
   logic                    out_inexact;

   // Producer of operands and consumer of results
   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_inexact
   );

   // The normalise/round stage itself
   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_inexact
   );
endinterface
`default_nettype wire

// File: rtl/fp_norm_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round_seq
// Description : Multi-cycle normalisation and round-to-nearest-even stage
//               of the IEEE-754 single-precision adder. Leading-one search
//               uses an 8-bit priority window: coarse byte shifts first,
//               then one fine bit shift, then rounding and packing.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round_seq #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  wire logic          clk,
   input  wire logic          reset,
   fp_norm_round_seq_if.slave bus
);

   // Mantissa layout: {carry, hidden, frac, guard, sticky}
   localparam int c_MW = FRAC_W + 4;
   localparam int c_HB = FRAC_W + 2;   // hidden-bit index
   localparam int c_CB = FRAC_W + 3;   // carry-bit index
   // Exponent carried two bits wider than the field so it never wraps
   localparam int c_XW = EXP_W + 2;
   localparam logic [c_XW-1:0] c_EXP_INF = c_XW'((1 << EXP_W) - 1);
   localparam logic [c_XW-1:0] c_BYTE    = c_XW'(8);
   localparam logic [c_XW-1:0] c_ONE     = c_XW'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_NORM_BYTE = 3'd1,
      S_NORM_BIT  = 3'd2,
      S_ROUND     = 3'd3,
      S_OUT       = 3'd4
   } state_t;

   state_t                r_state;
   logic                  r_sign;
   logic [c_XW-1:0]       r_exp;
   logic [c_MW-1:0]       r_mant;
   logic                  r_sub;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [EXP_W+FRAC_W:0] r_result;
   logic                  r_ovf;
   logic                  r_inx;

   // Leading-one search window: the byte just below the carry bit
   logic [7:0]            w_win;
   logic [7:0]            w_onehot;
   logic [3:0]            w_lzc;
   logic [c_XW-1:0]       w_exp_m1;
   logic [c_XW-1:0]       w_shamt;
   logic [c_MW-1:0]       w_mant_sh;

   // Rounding datapath
   logic                  w_lsb;
   logic                  w_g;
   logic                  w_st;
   logic                  w_up;
   logic [FRAC_W+1:0]     w_sum;
   logic                  w_carry;
   logic [FRAC_W-1:0]     w_frac;
   logic [c_XW-1:0]       w_exp_rnd;
   logic [EXP_W-1:0]      w_exp_field;
   logic                  w_ovf;

   assign w_win = r_mant[c_HB -: 8];

   // 8-bit priority circuit: one-hot of the most significant set bit
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < 8; i++) begin
         if (w_win[i]) w_onehot = 8'(1) << i;
      end
   end

   // Leading-zero count from the one-hot; 8 when the window is empty
   always_comb begin
      w_lzc = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (w_onehot[i]) w_lzc = 4'(7 - i);
      end
   end

   // Fine shift is limited so the exponent stops at 1 (subnormal boundary)
   always_comb begin
      w_exp_m1  = r_exp - c_ONE;
      w_shamt   = (c_XW'(w_lzc) < w_exp_m1) ? c_XW'(w_lzc) : w_exp_m1;
      w_mant_sh = r_mant << w_shamt;
   end

   // Round-to-nearest-even on the normalised mantissa and pack the fields
   always_comb begin
      w_lsb     = r_mant[2];
      w_g       = r_mant[1];
      w_st      = r_mant[0];
      w_up      = w_g & (w_st | w_lsb);
      w_sum     = r_mant[c_CB:2] + (FRAC_W + 2)'(w_up);
      w_carry   = w_sum[FRAC_W+1];
      w_frac    = w_carry ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
      w_exp_rnd = r_exp + c_XW'(w_carry);
      // A subnormal that rounds into the hidden bit becomes the smallest normal
      w_exp_field = r_sub ? EXP_W'(w_sum[FRAC_W]) : w_exp_rnd[EXP_W-1:0];
      w_ovf       = !r_sub && (w_exp_rnd >= c_EXP_INF);
   end

   // Control FSM with registered handshake outputs and result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
         r_sub       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_inx       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_sign     <= bus.in_sign;
                  r_exp      <= c_XW'(bus.in_exp);
                  r_mant     <= bus.in_mant;
                  r_sub      <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_NORM_BYTE;
               end
            end

            S_NORM_BYTE: begin
               if (r_mant[c_CB]) begin
                  // Carry out of the add: shift right, folding guard into sticky
                  r_mant  <= {1'b0, r_mant[c_CB:2], r_mant[1] | r_mant[0]};
                  r_exp   <= r_exp + c_ONE;
                  r_state <= S_ROUND;
               end else if (r_mant == '0) begin
                  // Exact cancellation: signed zero, no rounding needed
                  r_result    <= {r_sign, {(EXP_W + FRAC_W){1'b0}}};
                  r_ovf       <= 1'b0;
                  r_inx       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end else if ((w_win == 8'd0) && (r_exp > c_BYTE)) begin
                  r_mant <= r_mant << 8;
                  r_exp  <= r_exp - c_BYTE;
               end else begin
                  r_state <= S_NORM_BIT;
               end
            end

            S_NORM_BIT: begin
               r_mant  <= w_mant_sh;
               r_exp   <= r_exp - w_shamt;
               r_sub   <= ~w_mant_sh[c_HB];
               r_state <= S_ROUND;
            end

            S_ROUND: begin
               r_inx       <= w_g | w_st;
               r_out_valid <= 1'b1;
               if (w_ovf) begin
                  r_result <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                  r_ovf    <= 1'b1;
               end else begin
                  r_result <= {r_sign, w_exp_field, w_frac};
                  r_ovf    <= 1'b0;
               end
               r_state <= S_OUT;
            end

            S_OUT: begin
               if (r_out_valid && bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_result   = r_result;
   assign bus.out_overflow = r_ovf;
   assign bus.out_inexact  = r_inx;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_norm_round_seq
// Description : Directed self-checking bench for fp_norm_round_seq with
//               hand-computed results, latencies, flags and handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round_seq;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   fp_norm_round_seq_if bus ();

   fp_norm_round_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Issue one operand and check result, flags, latency and release handshake
   task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [26:0] m, input logic [31:0] res,
                         input logic ovf, input logic inx, input int lat, input int hold);
      int cyc;
      int w;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, "_in_ready"}, bus.in_ready, 1);
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      bus.in_sign   = s;
      bus.in_exp    = e;
      bus.in_mant   = m;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, cyc, lat);
      check({tag, "_res"}, bus.out_result, res);
      check({tag, "_ovf"}, bus.out_overflow, ovf);
      check({tag, "_inx"}, bus.out_inexact, inx);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_res"}, bus.out_result, res);
         check({tag, "_hold_vld"}, bus.out_valid, 1);
         check({tag, "_hold_rdy"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_rel_vld"}, bus.out_valid, 0);
      check({tag, "_rel_rdy"}, bus.in_ready, 1);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = 8'd0;
      bus.in_mant   = 27'd0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.out_result, 32'h0);
      check("rst_ovf", bus.out_overflow, 0);
      check("rst_inx", bus.out_inexact, 0);

      // tag, sign, exp, mant, result, ovf, inexact, latency, hold
      run_op("one",       1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3, 0);
      run_op("carry",     1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 2, 0);
      run_op("cancel",    1'b0, 8'd127, 27'h0000004, 32'h34000000, 1'b0, 1'b0, 5, 0);
      run_op("rnd_carry", 1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b1, 3, 0);
      run_op("ovf_carry", 1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
      run_op("neg_zero",  1'b1, 8'd127, 27'h0000000, 32'h80000000, 1'b0, 1'b0, 1, 0);
      run_op("subn",      1'b0, 8'd1,   27'h1000000, 32'h00400000, 1'b0, 1'b0, 3, 0);
      run_op("tie_even",  1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b1, 3, 0);
      run_op("rnd_up",    1'b0, 8'd127, 27'h2000003, 32'h3F800001, 1'b0, 1'b1, 3, 0);
      run_op("carry_stk", 1'b0, 8'd127, 27'h4000003, 32'h40000000, 1'b0, 1'b1, 2, 0);
      run_op("subn_lim",  1'b0, 8'd3,   27'h0200000, 32'h00200000, 1'b0, 1'b0, 3, 0);
      run_op("subn_norm", 1'b0, 8'd1,   27'h1FFFFFE, 32'h00800000, 1'b0, 1'b1, 3, 0);
      run_op("ovf_rnd",   1'b0, 8'd254, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b1, 3, 0);
      run_op("lowexp",    1'b0, 8'd5,   27'h0000004, 32'h00000010, 1'b0, 1'b0, 3, 0);
      run_op("bp",        1'b1, 8'd130, 27'h3000000, 32'hC1400000, 1'b0, 1'b0, 3, 4);

      // Reset while byte-normalising discards the operation
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_exp   = 8'd127;
      bus.in_mant  = 27'h0000004;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_result", bus.out_result, 32'h0);
      repeat (6) @(posedge clk);
      #1;
      check("midrst_no_out", bus.out_valid, 0);

      run_op("post_rst",  1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
